// File: rtl/shift_unit_seq.sv
// Iterative shifter (sll/srl/sra/rotr) that moves up to STEP bit positions per clock.
// Latency: ceil(shamt/STEP)+1 edges from the accepting edge to out_valid.
// Backpressure: holds the result in DONE while out_ready=0; accepts only in IDLE.
module shift_unit_seq #(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 4,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_SLL  = 2'd0;
  localparam logic [1:0] MODE_SRL  = 2'd1;
  localparam logic [1:0] MODE_SRA  = 2'd2;

  // One extra bit so STEP==WIDTH and WIDTH itself are representable.
  localparam logic [SHW:0] STEP_W  = (SHW+1)'(STEP);
  localparam logic [SHW:0] WIDTH_W = (SHW+1)'(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] acc;
  logic [SHW-1:0]   rem;
  logic [1:0]       mode;
  logic [SHW-1:0]   k;
  logic [WIDTH-1:0] acc_step;

  // State register; reset wins over every other event.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = SHIFT;
      SHIFT:   if (rem == '0) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs are pure functions of the state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // One partial shift: k = min(rem, STEP); k is never 0 when this result is used.
  always_comb begin
    k = ({1'b0, rem} > STEP_W) ? STEP_W[SHW-1:0] : rem;
    case (mode)
      MODE_SLL: acc_step = acc << k;
      MODE_SRL: acc_step = acc >> k;
      MODE_SRA: acc_step = $unsigned($signed(acc) >>> k);
      default:  acc_step = (acc >> k) | (acc << (WIDTH_W - {1'b0, k}));
    endcase
  end

  // Datapath: capture operands on accept, step the accumulator, publish the result.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc      <= '0;
      rem      <= '0;
      mode     <= '0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc  <= in_data;
            rem  <= in_shamt;
            mode <= in_mode;
          end
        end
        SHIFT: begin
          if (rem == '0) begin
            out_data <= acc;
          end else begin
            acc <= acc_step;
            rem <= rem - k;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_unit_seq.sv
// Bench for shift_unit_seq: three builds (STEP=4, 1, 32) share one stimulus stream.
// A cycle-level reference model per build is checked on every negedge.
// Directed cases pin literal results and latencies on the STEP=4 build.
module tb_shift_unit_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_mode;
  logic [2:0]  in_ready;
  logic [2:0]  out_valid;
  logic [2:0]  busy;
  logic [31:0] out_data [3];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  shift_unit_seq #(.WIDTH(32), .STEP(4)) u_s4 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode), .out_valid(out_valid[0]),
    .out_ready(out_ready), .out_data(out_data[0]), .busy(busy[0]));

  shift_unit_seq #(.WIDTH(32), .STEP(1)) u_s1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode), .out_valid(out_valid[1]),
    .out_ready(out_ready), .out_data(out_data[1]), .busy(busy[1]));

  shift_unit_seq #(.WIDTH(32), .STEP(32)) u_s32 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready[2]),
    .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode), .out_valid(out_valid[2]),
    .out_ready(out_ready), .out_data(out_data[2]), .busy(busy[2]));

  // Single-shot reference for each mode.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int sh, input logic [1:0] m);
    logic [63:0] ext;
    case (m)
      2'd0:    return d << sh;
      2'd1:    return d >> sh;
      2'd2: begin
        ext = {{32{d[31]}}, d} >> sh;
        return ext[31:0];
      end
      default: begin
        ext = {d, d} >> sh;
        return ext[31:0];
      end
    endcase
  endfunction

  task automatic check(input string nm, input int inst, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s inst%0d got %h expected %h at %0t", nm, inst, got, exp, $time);
    end
  endtask

  // Behavioural model: each build is idle, counting down to its result, or holding a result.
  int          steps [3] = '{4, 1, 32};
  bit          m_idle [3] = '{1'b1, 1'b1, 1'b1};
  bit          m_done [3] = '{1'b0, 1'b0, 1'b0};
  int          m_cnt  [3] = '{0, 0, 0};
  logic [31:0] m_res  [3];
  logic [31:0] m_out  [3] = '{32'h0, 32'h0, 32'h0};
  bit          checking = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset_n) begin
        m_idle[i] = 1'b1;
        m_done[i] = 1'b0;
        m_cnt[i]  = 0;
        m_out[i]  = 32'h0;
      end else if (m_idle[i]) begin
        if (in_valid) begin
          m_idle[i] = 1'b0;
          m_cnt[i]  = (int'(in_shamt) + steps[i] - 1) / steps[i] + 1;
          m_res[i]  = ref_shift(in_data, int'(in_shamt), in_mode);
        end
      end else if (!m_done[i]) begin
        m_cnt[i]--;
        if (m_cnt[i] == 0) begin
          m_done[i] = 1'b1;
          m_out[i]  = m_res[i];
        end
      end else if (out_ready) begin
        m_done[i] = 1'b0;
        m_idle[i] = 1'b1;
      end
    end
    if (!reset_n) checking = 1'b1;
  end

  // Compare every build against the model once per cycle, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < 3; i++) begin
        check("in_ready",  i, {31'b0, in_ready[i]},  {31'b0, m_idle[i]});
        check("out_valid", i, {31'b0, out_valid[i]}, {31'b0, m_done[i]});
        check("busy",      i, {31'b0, busy[i]},      {31'b0, !m_idle[i]});
        check("out_data",  i, out_data[i],           m_out[i]);
      end
    end
  end

  // Wait for all three builds to be idle; optionally jitter out_ready meanwhile.
  task automatic wait_all_idle(input bit rand_rdy);
    int n = 0;
    while (in_ready !== 3'b111 && n < 2000) begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    out_ready = 1'b1;
    vectors++;
    if (in_ready !== 3'b111) begin
      miscompares++;
      $display("FAIL idle_timeout got in_ready %b expected 111", in_ready);
    end
  endtask

  // Present one request for exactly the accepting edge, then scramble the inputs.
  task automatic issue(input logic [31:0] d, input logic [4:0] sh, input logic [1:0] m);
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = sh;
    in_mode  = m;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    in_shamt = 5'($urandom);
    in_mode  = 2'($urandom);
  endtask

  // Directed op on the STEP=4 build with literal result and latency.
  task automatic run_op(input string nm, input logic [31:0] d, input logic [4:0] sh,
                        input logic [1:0] m, input logic [31:0] exp_d, input int exp_lat);
    int lat = 0;
    issue(d, sh, m);
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid[0] && lat < 100);
    check({nm, "_lat"},  0, 32'(lat), 32'(exp_lat));
    check({nm, "_data"}, 0, out_data[0], exp_d);
    wait_all_idle(1'b0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_data   = '0;
    in_shamt  = '0;
    in_mode   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  0, {29'b0, in_ready},  32'h7);
    check("rst_out_valid", 0, {29'b0, out_valid}, 32'h0);
    check("rst_busy",      0, {29'b0, busy},      32'h0);
    check("rst_out_data",  0, out_data[0],        32'h0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("sll1",  32'h0000_0001, 5'd2,  2'd0, 32'h0000_0004, 2);
    run_op("sra31", 32'h8000_0000, 5'd31, 2'd2, 32'hFFFF_FFFF, 9);
    run_op("srl31", 32'h8000_0000, 5'd31, 2'd1, 32'h0000_0001, 9);
    run_op("rotr4", 32'h0000_00F1, 5'd4,  2'd3, 32'h1000_000F, 2);
    for (int m = 0; m < 4; m++) begin
      run_op("zero_sh", 32'hDEAD_BEEF, 5'd0, 2'(m), 32'hDEAD_BEEF, 1);
    end

    // Backpressure: hold the result for 5 cycles, then release with a new request waiting.
    out_ready = 1'b0;
    issue(32'h1234_5678, 5'd5, 2'd0);
    for (int n = 0; n < 100 && !out_valid[0]; n++) begin
      @(posedge clk);
      #1;
    end
    repeat (5) @(posedge clk);
    #1;
    check("bp_out_valid", 0, {31'b0, out_valid[0]}, 32'h1);
    check("bp_in_ready",  0, {31'b0, in_ready[0]},  32'h0);
    check("bp_out_data",  0, out_data[0],           32'h468A_CF00);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h0000_00A5;
    in_shamt  = 5'd0;
    in_mode   = 2'd0;
    @(posedge clk);
    #1;
    check("rel_in_ready",  0, {31'b0, in_ready[0]},  32'h1);
    check("rel_out_valid", 0, {31'b0, out_valid[0]}, 32'h0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("rel_accept", 0, {31'b0, busy[0]}, 32'h1);
    wait_all_idle(1'b0);
    check("rel_data", 0, out_data[0], 32'h0000_00A5);

    // Reset in the middle of a long shift aborts it.
    issue(32'h0000_0001, 5'd31, 2'd0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("mid_rst_data",  0, out_data[0],        32'h0);
    check("mid_rst_ready", 0, {29'b0, in_ready},  32'h7);
    repeat (40) @(posedge clk);
    #1;

    // Random operations with random output backpressure.
    for (int n = 0; n < 150; n++) begin
      issue($urandom, 5'($urandom), 2'($urandom));
      wait_all_idle(1'b1);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
